// File: rtl/sensor_lcd_scheduler.sv
// Poll sequencer for the sensor-to-LCD path, 1 MHz I2C clock domain.
// Reads one frame per period, refreshes the LCD only on change, counts errors.
module sensor_lcd_scheduler #(
  parameter int POLL_PERIOD   = 100000,
  parameter int RD_TIMEOUT    = 5000,
  parameter int PARSE_WIN     = 4,
  parameter int DISP_TIMEOUT  = 50000,
  parameter int THRESH        = 100,
  parameter int FORCE_REFRESH = 10
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       enable,
  output logic       rd_req,
  input  logic       rd_done,
  input  logic       frame_valid,
  input  logic [7:0] frame_data,
  output logic       disp_req,
  input  logic       disp_done,
  output logic [7:0] disp_data,
  output logic       alarm,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int M1 = (POLL_PERIOD > RD_TIMEOUT) ? POLL_PERIOD : RD_TIMEOUT;
  localparam int M2 = (PARSE_WIN > DISP_TIMEOUT) ? PARSE_WIN : DISP_TIMEOUT;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MX + 1);
  localparam int SW = $clog2(FORCE_REFRESH + 1);

  typedef enum logic [4:0] {
    S_WAIT    = 5'b00001,
    S_READ    = 5'b00010,
    S_PARSE   = 5'b00100,
    S_DECIDE  = 5'b01000,
    S_DISPLAY = 5'b10000
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [SW-1:0]   skip_q;
  logic [7:0]      sample_q;
  logic            first_q;

  logic            tmr_run;
  logic            tmr_clr;
  logic            err_inc;
  logic            latch;
  logic            refresh;
  logic            skip_inc;

  logic            hit_poll;
  logic            hit_rd;
  logic            hit_parse;
  logic            hit_disp;
  logic            force_hit;
  logic            smp_alarm;

  assign hit_poll  = timer_q == TW'(POLL_PERIOD - 1);
  assign hit_rd    = timer_q == TW'(RD_TIMEOUT - 1);
  assign hit_parse = timer_q == TW'(PARSE_WIN - 1);
  assign hit_disp  = timer_q == TW'(DISP_TIMEOUT - 1);
  assign force_hit = skip_q == SW'(FORCE_REFRESH - 1);
  assign smp_alarm = 32'(sample_q) <= THRESH;

  always_comb begin
    state_d  = state_q;
    tmr_run  = 1'b0;
    err_inc  = 1'b0;
    latch    = 1'b0;
    refresh  = 1'b0;
    skip_inc = 1'b0;
    unique case (1'b1)
      state_q[0]: begin
        tmr_run = enable;
        if (enable && hit_poll)
          state_d = S_READ;
      end
      state_q[1]: begin
        tmr_run = 1'b1;
        // a parsed frame may coincide with rd_done; it wins
        if (frame_valid) begin
          latch   = 1'b1;
          state_d = S_DECIDE;
        end else if (rd_done) begin
          state_d = S_PARSE;
        end else if (hit_rd) begin
          err_inc = 1'b1;
          state_d = S_WAIT;
        end
      end
      state_q[2]: begin
        tmr_run = 1'b1;
        if (frame_valid) begin
          latch   = 1'b1;
          state_d = S_DECIDE;
        end else if (hit_parse) begin
          err_inc = 1'b1;
          state_d = S_WAIT;
        end
      end
      state_q[3]: begin
        if (first_q || sample_q != disp_data || force_hit) begin
          refresh = 1'b1;
          state_d = S_DISPLAY;
        end else begin
          skip_inc = 1'b1;
          state_d  = S_WAIT;
        end
      end
      state_q[4]: begin
        tmr_run = 1'b1;
        if (disp_done) begin
          state_d = S_WAIT;
        end else if (hit_disp) begin
          err_inc = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // idle timer only advances while polling is permitted
  assign tmr_clr = (state_d != state_q) || (state_q[0] && !enable);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (tmr_clr)
        timer_q <= '0;
      else if (tmr_run)
        timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      rd_req    <= 1'b0;
      disp_req  <= 1'b0;
      busy      <= 1'b0;
      disp_data <= 8'd0;
      alarm     <= 1'b1;
      err_cnt   <= 8'd0;
      skip_q    <= '0;
      sample_q  <= 8'd0;
      first_q   <= 1'b1;
    end else begin
      rd_req   <= state_d == S_READ;
      disp_req <= state_d == S_DISPLAY;
      busy     <= state_d != S_WAIT;
      if (latch)
        sample_q <= frame_data;
      if (refresh) begin
        disp_data <= sample_q;
        alarm     <= smp_alarm;
        first_q   <= 1'b0;
        skip_q    <= '0;
      end else if (skip_inc) begin
        skip_q <= skip_q + 1'b1;
      end
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
